// File: rtl/tile_nv_fetch_sched_pkg.sv
// Shared types and constants for the NV tile-store fetch scheduler.
// Optional feature macro used by the top: TILE_NV_SCHED_PERF_EN.
package gemm_pkg;

  localparam int NV_DEPTH  = 128;
  localparam int IDX_WIDTH = $clog2(NV_DEPTH);
  localparam int DIM_WIDTH = 8;

  typedef logic [IDX_WIDTH-1:0] nv_idx_t;
  typedef logic [DIM_WIDTH-1:0] tile_dim_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  typedef struct packed {
    nv_idx_t   left_base;
    nv_idx_t   right_base;
    tile_dim_t dim_b;
    tile_dim_t dim_c;
    tile_dim_t dim_v;
  } tile_cmd_t;

  // True when rows*v NVs starting at base stay inside the store (full-width product).
  function automatic logic side_fits(input nv_idx_t base, input tile_dim_t rows,
                                     input tile_dim_t v);
    logic [15:0] need;
    logic [15:0] room;
    need = 16'(rows) * 16'(v);
    room = 16'(NV_DEPTH) - 16'(base);
    return (need <= room);
  endfunction

endpackage

// File: rtl/tile_nv_fetch_sched_if.sv
// Command and NV-pair handshake bundle between decoder, scheduler and dot-product engine.
interface tile_nv_fetch_sched_if;
  import gemm_pkg::*;

  logic      cmd_valid;
  logic      cmd_ready;
  nv_idx_t   cmd_left_base;
  nv_idx_t   cmd_right_base;
  tile_dim_t cmd_dim_b;
  tile_dim_t cmd_dim_c;
  tile_dim_t cmd_dim_v;
  logic      wr_busy;
  nv_idx_t   nv_left_rd_idx;
  nv_idx_t   nv_right_rd_idx;
  logic      nv_valid;
  logic      nv_ready;
  logic      nv_last;
  logic      done;
  logic      cmd_err;

  modport master (
    output cmd_valid, cmd_left_base, cmd_right_base, cmd_dim_b, cmd_dim_c, cmd_dim_v,
    output wr_busy, nv_ready,
    input  cmd_ready, nv_left_rd_idx, nv_right_rd_idx, nv_valid, nv_last, done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_left_base, cmd_right_base, cmd_dim_b, cmd_dim_c, cmd_dim_v,
    input  wr_busy, nv_ready,
    output cmd_ready, nv_left_rd_idx, nv_right_rd_idx, nv_valid, nv_last, done, cmd_err
  );

endinterface

// File: rtl/tile_nv_fetch_sched_loop_cnt.sv
// Wrapping loop counter: load captures the trip count, enable steps, last flags the final trip.
module tile_loop_cnt
  import gemm_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset_n,
  input  logic      i_load,
  input  logic      i_en,
  input  tile_dim_t i_limit,
  output logic      o_last
);

  tile_dim_t cnt_q, cnt_d;
  tile_dim_t limit_q, limit_d;

  assign o_last = (cnt_q == tile_dim_t'(limit_q - tile_dim_t'(1)));

  always_comb begin
    cnt_d   = cnt_q;
    limit_d = limit_q;
    if (i_load) begin
      cnt_d   = '0;
      limit_d = i_limit;
    end else if (i_en) begin
      cnt_d = o_last ? '0 : tile_dim_t'(cnt_q + tile_dim_t'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: rtl/tile_nv_fetch_sched.sv
// NV read scheduler: walks left/right tile-store indices in b->c->v order for one GEMM tile command.
// Optional perf counters behind TILE_NV_SCHED_PERF_EN.
//   state | meaning
//   IDLE  | waiting for a command (or one decode cycle for an empty command)
//   RUN   | presenting NV pairs, one beat per valid&ready
//   DONE  | one-cycle completion pulse
module tile_nv_fetch_sched
  import gemm_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  tile_nv_fetch_sched_if.slave bus
`ifdef TILE_NV_SCHED_PERF_EN
  ,
  output logic [31:0]          o_perf_busy_cycles,
  output logic [31:0]          o_perf_stall_cycles
`endif
);

  sched_state_e state_q, state_d;
  nv_idx_t      l_row_q, l_row_d;
  nv_idx_t      l_idx_q, l_idx_d;
  nv_idx_t      r_base_q, r_base_d;
  nv_idx_t      r_col_q, r_col_d;
  nv_idx_t      r_idx_q, r_idx_d;
  nv_idx_t      v_step_q, v_step_d;
  logic         err_q, err_d;
  logic         zero_q, zero_d;

  tile_cmd_t cmd;
  logic      cmd_ready;
  logic      accept;
  logic      range_bad;
  logic      dim_zero;
  logic      load;
  logic      beat;
  logic      v_last, c_last, b_last;
  logic      final_beat;

  assign cmd.left_base  = bus.cmd_left_base;
  assign cmd.right_base = bus.cmd_right_base;
  assign cmd.dim_b      = bus.cmd_dim_b;
  assign cmd.dim_c      = bus.cmd_dim_c;
  assign cmd.dim_v      = bus.cmd_dim_v;

  assign range_bad = !side_fits(cmd.left_base, cmd.dim_b, cmd.dim_v)
                  || !side_fits(cmd.right_base, cmd.dim_c, cmd.dim_v);
  assign dim_zero  = (cmd.dim_b == '0) || (cmd.dim_c == '0) || (cmd.dim_v == '0);

  assign cmd_ready  = i_reset_n && (state_q == IDLE) && !zero_q && !bus.wr_busy;
  assign accept     = bus.cmd_valid && cmd_ready;
  assign load       = accept && !range_bad && !dim_zero;
  assign beat       = (state_q == RUN) && bus.nv_ready;
  assign final_beat = beat && v_last && c_last && b_last;

  tile_loop_cnt u_cnt_v (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_load   (load),
    .i_en     (beat),
    .i_limit  (cmd.dim_v),
    .o_last   (v_last)
  );

  tile_loop_cnt u_cnt_c (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_load   (load),
    .i_en     (beat && v_last),
    .i_limit  (cmd.dim_c),
    .o_last   (c_last)
  );

  tile_loop_cnt u_cnt_b (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_load   (load),
    .i_en     (beat && v_last && c_last),
    .i_limit  (cmd.dim_b),
    .o_last   (b_last)
  );

  always_comb begin
    state_d  = state_q;
    l_row_d  = l_row_q;
    l_idx_d  = l_idx_q;
    r_base_d = r_base_q;
    r_col_d  = r_col_q;
    r_idx_d  = r_idx_q;
    v_step_d = v_step_q;
    err_d    = 1'b0;
    zero_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Empty commands spend one decode cycle here so completion mirrors the error timing.
        if (zero_q) begin
          state_d = DONE;
        end else if (accept) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else if (dim_zero) begin
            zero_d = 1'b1;
          end else begin
            state_d  = RUN;
            l_row_d  = cmd.left_base;
            l_idx_d  = cmd.left_base;
            r_base_d = cmd.right_base;
            r_col_d  = cmd.right_base;
            r_idx_d  = cmd.right_base;
            v_step_d = cmd.dim_v[IDX_WIDTH-1:0];
          end
        end
      end
      RUN: begin
        if (beat) begin
          if (!v_last) begin
            l_idx_d = nv_idx_t'(l_idx_q + nv_idx_t'(1));
            r_idx_d = nv_idx_t'(r_idx_q + nv_idx_t'(1));
          end else if (!c_last) begin
            l_idx_d = l_row_q;
            r_col_d = nv_idx_t'(r_col_q + v_step_q);
            r_idx_d = nv_idx_t'(r_col_q + v_step_q);
          end else begin
            l_row_d = nv_idx_t'(l_row_q + v_step_q);
            l_idx_d = nv_idx_t'(l_row_q + v_step_q);
            r_col_d = r_base_q;
            r_idx_d = r_base_q;
          end
          if (final_beat) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      l_row_q  <= '0;
      l_idx_q  <= '0;
      r_base_q <= '0;
      r_col_q  <= '0;
      r_idx_q  <= '0;
      v_step_q <= '0;
      err_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      l_row_q  <= l_row_d;
      l_idx_q  <= l_idx_d;
      r_base_q <= r_base_d;
      r_col_q  <= r_col_d;
      r_idx_q  <= r_idx_d;
      v_step_q <= v_step_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.cmd_ready       = cmd_ready;
  assign bus.nv_left_rd_idx  = l_idx_q;
  assign bus.nv_right_rd_idx = r_idx_q;
  assign bus.nv_valid        = (state_q == RUN);
  assign bus.nv_last         = (state_q == RUN) && v_last;
  assign bus.done            = (state_q == DONE);
  assign bus.cmd_err         = err_q;

`ifdef TILE_NV_SCHED_PERF_EN
  logic [31:0] busy_q, busy_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if (accept) begin
      busy_d  = '0;
      stall_d = '0;
    end else if (state_q == RUN) begin
      if (busy_q != '1) busy_d = busy_q + 32'd1;
      if (!bus.nv_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign o_perf_busy_cycles  = busy_q;
  assign o_perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_tile_nv_fetch_sched.sv
// Directed bench for tile_nv_fetch_sched; perf checks compile in with TILE_NV_SCHED_PERF_EN.
module tb_tile_nv_fetch_sched;
  import gemm_pkg::*;

  logic clk;
  logic reset_n;
  int   tests;
  int   failed;

  tile_nv_fetch_sched_if bus ();

`ifdef TILE_NV_SCHED_PERF_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_stall;
`endif

  tile_nv_fetch_sched dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .bus      (bus)
`ifdef TILE_NV_SCHED_PERF_EN
    ,
    .o_perf_busy_cycles (perf_busy),
    .o_perf_stall_cycles(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one command for a single cycle; it must be accepted on that edge.
  task automatic send(input string tag, input int lb, input int rb, input int b, input int c,
                      input int v);
    bus.cmd_left_base  = nv_idx_t'(lb);
    bus.cmd_right_base = nv_idx_t'(rb);
    bus.cmd_dim_b      = tile_dim_t'(b);
    bus.cmd_dim_c      = tile_dim_t'(c);
    bus.cmd_dim_v      = tile_dim_t'(v);
    bus.cmd_valid      = 1'b1;
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Check the pair on offer this cycle, then let the clock edge consume it.
  task automatic beat(input string tag, input int l, input int r, input logic last);
    check({tag, "_valid"}, 32'(bus.nv_valid), 32'd1);
    check({tag, "_left"}, 32'(bus.nv_left_rd_idx), 32'(l));
    check({tag, "_right"}, 32'(bus.nv_right_rd_idx), 32'(r));
    check({tag, "_last"}, 32'(bus.nv_last), 32'(last));
    tick();
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_valid_off"}, 32'(bus.nv_valid), 32'd0);
    check({tag, "_ready_in_done"}, 32'(bus.cmd_ready), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  int exp_l2[8] = '{10, 11, 10, 11, 12, 13, 12, 13};
  int exp_r2[8] = '{20, 21, 22, 23, 20, 21, 22, 23};

  initial begin
    tests = 0;
    failed = 0;
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_left_base = '0;
    bus.cmd_right_base = '0;
    bus.cmd_dim_b = '0;
    bus.cmd_dim_c = '0;
    bus.cmd_dim_v = '0;
    bus.wr_busy = 1'b0;
    bus.nv_ready = 1'b1;
    tick();
    tick();

    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_valid", 32'(bus.nv_valid), 32'd0);
    check("rst_left", 32'(bus.nv_left_rd_idx), 32'd0);
    check("rst_right", 32'(bus.nv_right_rd_idx), 32'd0);
    check("rst_last", 32'(bus.nv_last), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.cmd_err), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // 1: single dot product of 4 NVs
    send("t1", 0, 0, 1, 1, 4);
    for (int i = 0; i < 4; i++) beat($sformatf("t1_b%0d", i), i, i, i == 3);
    expect_done("t1");

    // 2: 2x2 tile, V=2; wr_busy during RUN must not matter
    send("t2", 10, 20, 2, 2, 2);
    bus.wr_busy = 1'b1;
    for (int i = 0; i < 8; i++) beat($sformatf("t2_b%0d", i), exp_l2[i], exp_r2[i], i % 2 == 1);
    bus.wr_busy = 1'b0;
    expect_done("t2");

    // 3: stall three cycles on the second beat
    send("t3", 0, 0, 1, 1, 4);
    beat("t3_b0", 0, 0, 1'b0);
    bus.nv_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_hold%0d_left", i), 32'(bus.nv_left_rd_idx), 32'd1);
      check($sformatf("t3_hold%0d_valid", i), 32'(bus.nv_valid), 32'd1);
      tick();
    end
    bus.nv_ready = 1'b1;
    beat("t3_b1", 1, 1, 1'b0);
    beat("t3_b2", 2, 2, 1'b0);
    beat("t3_b3", 3, 3, 1'b1);
`ifdef TILE_NV_SCHED_PERF_EN
    check("t8_perf_busy", perf_busy, 32'd7);
    check("t8_perf_stall", perf_stall, 32'd3);
`endif
    expect_done("t3");

    // 4: left side overflows by one NV
    send("t4", 120, 0, 1, 1, 9);
    check("t4_err", 32'(bus.cmd_err), 32'd1);
    check("t4_valid", 32'(bus.nv_valid), 32'd0);
    check("t4_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    check("t4_err_pulse", 32'(bus.cmd_err), 32'd0);
    check("t4_no_done", 32'(bus.done), 32'd0);

    // 4b: exactly fills the left side
    send("t4b", 120, 0, 1, 1, 8);
    check("t4b_err", 32'(bus.cmd_err), 32'd0);
    for (int i = 0; i < 8; i++) beat($sformatf("t4b_b%0d", i), 120 + i, i, i == 7);
    expect_done("t4b");

    // 5: empty command
    send("t5", 0, 0, 1, 1, 0);
    check("t5_valid", 32'(bus.nv_valid), 32'd0);
    check("t5_early_done", 32'(bus.done), 32'd0);
    check("t5_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    check("t5_valid2", 32'(bus.nv_valid), 32'd0);
    expect_done("t5");

    // 6: dispatch busy blocks acceptance
    bus.wr_busy = 1'b1;
    bus.cmd_valid = 1'b1;
    #1;
    check("t6_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    check("t6_no_run", 32'(bus.nv_valid), 32'd0);
    bus.cmd_valid = 1'b0;
    bus.wr_busy = 1'b0;
    #1;
    check("t6_ready_back", 32'(bus.cmd_ready), 32'd1);

    // 7: reset at the third beat of test 2, then a clean command
    send("t7", 10, 20, 2, 2, 2);
    beat("t7_b0", 10, 20, 1'b0);
    beat("t7_b1", 11, 21, 1'b1);
    reset_n = 1'b0;
    tick();
    check("t7_valid", 32'(bus.nv_valid), 32'd0);
    check("t7_left", 32'(bus.nv_left_rd_idx), 32'd0);
    check("t7_right", 32'(bus.nv_right_rd_idx), 32'd0);
    check("t7_last", 32'(bus.nv_last), 32'd0);
    check("t7_done", 32'(bus.done), 32'd0);
    check("t7_ready", 32'(bus.cmd_ready), 32'd0);
    reset_n = 1'b1;
    tick();
    check("t7_no_done", 32'(bus.done), 32'd0);
    send("t7r", 0, 0, 1, 1, 4);
    for (int i = 0; i < 4; i++) beat($sformatf("t7r_b%0d", i), i, i, i == 3);
    expect_done("t7r");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
